uberclock_sweep_ctrl: RTL
=========================

# uberclock_sweep_ctrl

Frequency-sweep scheduler for the uberclock receive path. Steps the down-conversion phase increment across a programmed list of frequencies, discards settling samples after each retune, then accumulates the decimated I/Q stream (`ce_down`-qualified) over a dwell window. Each step's sums are delivered to the CPU side through a valid/ready handshake. It sits between the CSR bank and the `rx_channel` instance and drives `phase_inc_down` in place of a static CSR.

## Interface
- `PW`, 19: phase increment width; matches the rx_channel down-conversion NCO.
- `DW`, 16: width of the signed decimated I/Q samples.
- `ACCW`, 32: width of the signed dwell accumulators; must be ≥ DW+16.

Ports:
- `sys_clk` in 1: the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level; sampled only in IDLE.
- `abort` in 1: level; takes effect in any state.
- `f_start` in PW: phase increment for step 0.
- `f_step` in PW: increment added per step; modulo 2^PW.
- `n_steps` in 16: number of steps; 0 is treated as 1.
- `settle_samples` in 16: `ce_down` samples discarded after each retune; 0 means no settle phase.
- `dwell_samples` in 16: `ce_down` samples accumulated per step; 0 is treated as 1.
- `ce_down` in 1: decimated-sample strobe from rx_channel.
- `data_x`, `data_y` in DW, signed: decimated I/Q; valid when `ce_down`=1.
- `phase_inc_down` out PW: drives the rx_channel down-conversion increment.
- `busy` out 1: high in SETTLE, DWELL and OUTPUT.
- `done` out 1: one-cycle pulse on normal completion.
- `result_valid` out 1: result holding register is full.
- `result_ready` in 1: consumer accepts the result.
- `result_idx` out 16: step index of the presented result.
- `result_sum_x`, `result_sum_y` out ACCW, signed: dwell sums.

## Operation
States are IDLE, SETTLE, DWELL, OUTPUT.
- **IDLE**
  - `start`=1 and `abort`=0 → latch `f_step`, `n_steps`, `settle_samples` and `dwell_samples`; load `phase_inc_down`←`f_start`; clear `idx` and the sample counter.
  - Go to SETTLE, or to DWELL if `settle_samples`=0.
  - Latched configuration is immune to CSR changes until the sweep ends.
- **SETTLE**
  - Count `ce_down` pulses; data is ignored.
  - On the pulse that brings the count to `settle_samples`: clear the counter and both accumulators, go to DWELL.
- **DWELL**
  - On each `ce_down`: acc_x += sign-extended `data_x`; acc_y likewise.
  - On the pulse that brings the count to `dwell_samples`, that sample is included. Then:
    - copy the final sums into `result_sum_x`/`result_sum_y`;
    - set `result_idx`←`idx`;
    - set `result_valid`←1, go to OUTPUT.
- **OUTPUT**
  - `ce_down` is ignored, and those samples are lost.
  - The sweep stalls indefinitely while `result_ready`=0.
  - Handshake cycle (`result_valid` & `result_ready`) clears `result_valid`, then:
    - if `idx`=`n_steps`−1: go to IDLE, assert `done` the next cycle;
    - else: `idx`+1, `phase_inc_down`+=`f_step` (wraps mod 2^PW), go to SETTLE (or DWELL if settle is 0).
- **Abort**
  - `abort`=1 in any state → IDLE next cycle; clears `result_valid`; no `done`; `busy`=0.
  - `phase_inc_down` holds its current value.
  - Abort overrides `start` and a simultaneous handshake; in that case the result counts as consumed.
- `start` while busy is ignored.
- `phase_inc_down` holds its last value in IDLE after completion.
- No overflow is possible: 65535 × 2^15 < 2^31.

## Timing
- Reset values: `phase_inc_down`=0, `busy`=0, `done`=0, `result_valid`=0, `result_idx`=0, `result_sum_x`=0, `result_sum_y`=0; state IDLE.
- `start` at cycle t → at t+1: `busy`=1 and `phase_inc_down`=`f_start`.
- Last dwell `ce_down` at cycle t → at t+1: `result_valid`=1 with stable data.
- Result outputs are held constant while `result_valid`=1.
- Handshake at cycle t, more steps remaining → at t+1: `result_valid`=0 and the new `phase_inc_down`; a `ce_down` at t+1 is counted.
- Final handshake at cycle t → at t+1: `done`=1 and `busy`=0; at t+2: `done`=0.
- `ce_down` in the same cycle as the SETTLE→DWELL transition is a settle sample, not a dwell sample.
- `result_valid` may depend on state only; there is no combinational path from `result_ready` to `result_valid`.
- All outputs are registered.

## Test plan
- **Basic 3-step sweep.** `f_start`=1000, `f_step`=500, `n_steps`=3, `settle`=2, `dwell`=4, `data_x`=+3, `data_y`=−2 on every `ce_down` (1 in 10 cycles), `result_ready`=1.
  - Expect three results, idx 0/1/2, sums +12/−8.
  - Expect `phase_inc_down` 1000→1500→2000.
  - Expect a single `done` pulse.
- **Back-pressure.** Hold `result_ready`=0 for 200 cycles on step 0.
  - `result_valid` and the data are held, `phase_inc_down` is unchanged, `ce_down` is ignored.
  - After release, step 1 proceeds normally.
- **Wrap-around.** `f_start`=2^19−100, `f_step`=300.
  - Step 1 `phase_inc_down`=200.
- **Zero-count edge cases.** `n_steps`=0, `settle`=0, `dwell`=0.
  - Exactly one result containing a single sample; DWELL entered at t+1; `done` follows.
- **Abort and restart.** Abort during DWELL of step 1 with `result_valid`=0, then restart.
  - `busy`=0 next cycle, no `done`, no result.
  - A fresh `start` restarts from `f_start` with idx 0.
- **Extremes and mid-sweep reset.**
  - `dwell`=65535, `data_x`=−32768 → `result_sum_x`=−2147450880.
  - `rst_n` asserted mid-sweep → all outputs at their reset values asynchronously.

Source files
------------

// File: rtl/uberclock_sweep_ctrl.sv
// Steps the down-conversion phase increment through a programmed frequency list, settles, then dwell-accumulates I/Q.
// Result appears one cycle after the last dwell sample; valid/ready output stalls the sweep until the result is accepted.
module uberclock_sweep_ctrl #(
    parameter int PW   = 19,
    parameter int DW   = 16,
    parameter int ACCW = 32
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PW-1:0]          f_start,
    input  logic [PW-1:0]          f_step,
    input  logic [15:0]            n_steps,
    input  logic [15:0]            settle_samples,
    input  logic [15:0]            dwell_samples,
    input  logic                   ce_down,
    input  logic signed [DW-1:0]   data_x,
    input  logic signed [DW-1:0]   data_y,
    output logic [PW-1:0]          phase_inc_down,
    output logic                   busy,
    output logic                   done,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [15:0]            result_idx,
    output logic signed [ACCW-1:0] result_sum_x,
    output logic signed [ACCW-1:0] result_sum_y
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_DWELL  = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    logic [1:0]             r_state;
    logic [PW-1:0]          r_f_step;
    logic [15:0]            r_n_steps;
    logic [15:0]            r_settle;
    logic [15:0]            r_dwell;
    logic [15:0]            r_idx;
    logic [15:0]            r_cnt;
    logic signed [ACCW-1:0] r_acc_x;
    logic signed [ACCW-1:0] r_acc_y;

    logic signed [ACCW-1:0] w_sum_x;
    logic signed [ACCW-1:0] w_sum_y;
    logic [16:0]            w_cnt_inc;
    logic                   w_settle_hit;
    logic                   w_dwell_hit;
    logic                   w_last_step;

    assign w_sum_x      = r_acc_x + {{(ACCW-DW){data_x[DW-1]}}, data_x};
    assign w_sum_y      = r_acc_y + {{(ACCW-DW){data_y[DW-1]}}, data_y};
    assign w_cnt_inc    = {1'b0, r_cnt} + 17'd1;
    assign w_settle_hit = (w_cnt_inc == {1'b0, r_settle});
    assign w_dwell_hit  = (w_cnt_inc == {1'b0, r_dwell});
    assign w_last_step  = (r_idx == r_n_steps - 16'd1);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_f_step       <= '0;
            r_n_steps      <= 16'd1;
            r_settle       <= '0;
            r_dwell        <= 16'd1;
            r_idx          <= '0;
            r_cnt          <= '0;
            r_acc_x        <= '0;
            r_acc_y        <= '0;
            phase_inc_down <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            result_valid   <= 1'b0;
            result_idx     <= '0;
            result_sum_x   <= '0;
            result_sum_y   <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // A pending result is dropped; phase increment stays where it was.
                r_state      <= S_IDLE;
                busy         <= 1'b0;
                result_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_f_step       <= f_step;
                            r_n_steps      <= (n_steps == 16'd0) ? 16'd1 : n_steps;
                            r_settle       <= settle_samples;
                            r_dwell        <= (dwell_samples == 16'd0) ? 16'd1 : dwell_samples;
                            phase_inc_down <= f_start;
                            r_idx          <= '0;
                            r_cnt          <= '0;
                            r_acc_x        <= '0;
                            r_acc_y        <= '0;
                            busy           <= 1'b1;
                            r_state        <= (settle_samples == 16'd0) ? S_DWELL : S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (ce_down) begin
                            if (w_settle_hit) begin
                                r_cnt   <= '0;
                                r_acc_x <= '0;
                                r_acc_y <= '0;
                                r_state <= S_DWELL;
                            end else begin
                                r_cnt <= w_cnt_inc[15:0];
                            end
                        end
                    end
                    S_DWELL: begin
                        if (ce_down) begin
                            if (w_dwell_hit) begin
                                result_sum_x <= w_sum_x;
                                result_sum_y <= w_sum_y;
                                result_idx   <= r_idx;
                                result_valid <= 1'b1;
                                r_state      <= S_OUTPUT;
                            end else begin
                                r_acc_x <= w_sum_x;
                                r_acc_y <= w_sum_y;
                                r_cnt   <= w_cnt_inc[15:0];
                            end
                        end
                    end
                    S_OUTPUT: begin
                        if (result_valid && result_ready) begin
                            result_valid <= 1'b0;
                            if (w_last_step) begin
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_idx          <= r_idx + 16'd1;
                                phase_inc_down <= phase_inc_down + r_f_step;
                                r_cnt          <= '0;
                                r_acc_x        <= '0;
                                r_acc_y        <= '0;
                                r_state        <= (r_settle == 16'd0) ? S_DWELL : S_SETTLE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
